mem_arbiter: RTL and testbench

Shares one downstream memory port between the cpu's instruction-fetch side and data side, so the core can run on a single unified memory. Each requester uses a level req / one-cycle ack handshake; the arbiter grants one requester at a time and forwards the access to the memory port. It holds the access until the memory acks or a timeout expires. It sits between the core's fetch/load-store logic and the memory, and its acks are the core's stall-release signals.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state and grant encodings shared by the unified-memory
// arbiter, its winner-select sub-module and the interface.
// Optional feature macro: MEM_ARB_RR_EN (round-robin conflict resolution).
package mem_arbiter_pkg;

   // Arbiter FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_BUSY = 2'b01,
      ARB_RESP = 2'b10
   } arb_state_t;

   // Owner of the current (or most recent) memory access.
   typedef enum logic {
      ARB_GNT_I = 1'b0,
      ARB_GNT_D = 1'b1
   } arb_gnt_t;

   // Data and address width of every bus in the block.
   localparam int unsigned ARB_DW = 32;

   // Default number of BUSY cycles allowed before an access is aborted.
   localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// core/memory environment.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   // Instruction-fetch requester
   logic              i_req;
   logic [ARB_DW-1:0] i_addr;
   logic              i_ack;
   logic [ARB_DW-1:0] i_rdata;

   // Data (load/store) requester
   logic              d_req;
   logic              d_write;
   logic [ARB_DW-1:0] d_addr;
   logic [ARB_DW-1:0] d_wdata;
   logic              d_ack;
   logic [ARB_DW-1:0] d_rdata;

   // Timeout flag, qualified by i_ack or d_ack
   logic              err;

   // Downstream memory port
   logic              m_req;
   logic              m_write;
   logic [ARB_DW-1:0] m_addr;
   logic [ARB_DW-1:0] m_wdata;
   logic              m_ack;
   logic [ARB_DW-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, m_ack, m_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, err,
             m_req, m_write, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_write, d_addr, d_wdata, m_ack, m_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, err,
             m_req, m_write, m_addr, m_wdata
   );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between the fetch and data
// requesters. With MEM_ARB_RR_EN defined a conflict goes to the side not
// granted last; otherwise the data side always wins a conflict.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic     i_req,
   input  logic     d_req,
   input  arb_gnt_t last_gnt,
   output logic     valid,
   output arb_gnt_t gnt
);

`ifndef MEM_ARB_RR_EN
   // Fixed priority never looks at the previous owner.
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

   // Select the winner; a lone requester always wins.
   // NOTE: every output gets a default before the branches, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      valid = i_req | d_req;
      gnt   = ARB_GNT_I;
      if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
         gnt = (last_gnt == ARB_GNT_D) ? ARB_GNT_I : ARB_GNT_D;
`else
         gnt = ARB_GNT_D;
`endif
      end else if (d_req) begin
         gnt = ARB_GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data
// accesses. IDLE grants a requester, BUSY forwards the access until the
// memory acks or TIMEOUT BUSY cycles pass, RESP pulses the owner's ack.
// Optional feature macro: MEM_ARB_RR_EN (round-robin, inside arb_pick).
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT  // legal 2..65535
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t        state_q, state_d;
   arb_gnt_t          gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              pick_valid;
   arb_gnt_t          pick_gnt;

   // Next values for the registered outputs
   logic              m_write_d;
   logic [ARB_DW-1:0] m_addr_d, m_wdata_d;
   logic              i_ack_d, d_ack_d;
   logic [ARB_DW-1:0] resp_rdata;
   logic              resp_err;

   // Registered outputs
   logic              m_req_q, m_write_q;
   logic [ARB_DW-1:0] m_addr_q, m_wdata_q;
   logic              i_ack_q, d_ack_q, err_q;
   logic [ARB_DW-1:0] i_rdata_q, d_rdata_q;

   arb_pick u_pick (
      .i_req    (bus.i_req),
      .d_req    (bus.d_req),
      .last_gnt (gnt_q),
      .valid    (pick_valid),
      .gnt      (pick_gnt)
   );

   // FSM state register.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ARB_IDLE;
      else       state_q <= state_d;
   end

   // Next-state, grant, timeout counter and response capture.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      cnt_d      = cnt_q;
      m_write_d  = m_write_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      resp_rdata = '0;
      resp_err   = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_BUSY;
               gnt_d   = pick_gnt;
               cnt_d   = '0;
               if (pick_gnt == ARB_GNT_D) begin
                  m_write_d = bus.d_write;
                  m_addr_d  = bus.d_addr;
                  m_wdata_d = bus.d_wdata;
               end else begin
                  m_write_d = 1'b0;
                  m_addr_d  = bus.i_addr;
                  m_wdata_d = '0;
               end
            end
         end
         ARB_BUSY: begin
            if (bus.m_ack) begin
               // A store returns no data to the core.
               resp_rdata = m_write_q ? '0 : bus.m_rdata;
               state_d    = ARB_RESP;
            end else if (cnt_q == CNT_LAST) begin
               resp_err = 1'b1;
               state_d  = ARB_RESP;
            end else begin
               // BUSY is left at CNT_LAST, so the counter stops there.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase

      i_ack_d = (state_d == ARB_RESP) && (gnt_d == ARB_GNT_I);
      d_ack_d = (state_d == ARB_RESP) && (gnt_d == ARB_GNT_D);
   end

   // Grant, counter and output registers; reset clears them asynchronously
   // so an in-flight access is dropped without an ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_q     <= ARB_GNT_I;
         cnt_q     <= '0;
         m_req_q   <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         err_q     <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         m_req_q   <= (state_d == ARB_BUSY);
         m_write_q <= m_write_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_ack_d ? resp_rdata : '0;
         d_rdata_q <= d_ack_d ? resp_rdata : '0;
         err_q     <= (state_d == ARB_RESP) ? resp_err : 1'b0;
      end
   end

   assign bus.m_req   = m_req_q;
   assign bus.m_write = m_write_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;
   assign bus.i_ack   = i_ack_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_ack   = d_ack_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (winner rule, latency and response per access).
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   bit   model_last_d;   // model: previous owner was the data side

   mem_arbiter_if bus ();

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Winner rule taken straight from the arbitration policy.
   function automatic bit pick_d(input bit i, input bit d);
      if (i && d) begin
`ifdef MEM_ARB_RR_EN
         return !model_last_d;
`else
         return 1'b1;
`endif
      end
      return d;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, " m_req"},   32'(bus.m_req),   32'd0);
      check({tag, " m_write"}, 32'(bus.m_write), 32'd0);
      check({tag, " m_addr"},  bus.m_addr,       32'd0);
      check({tag, " m_wdata"}, bus.m_wdata,      32'd0);
      check({tag, " i_ack"},   32'(bus.i_ack),   32'd0);
      check({tag, " d_ack"},   32'(bus.d_ack),   32'd0);
      check({tag, " i_rdata"}, bus.i_rdata,      32'd0);
      check({tag, " d_rdata"}, bus.d_rdata,      32'd0);
      check({tag, " err"},     32'(bus.err),     32'd0);
      check({tag, " state"},   32'(dut.state_q), 32'(ARB_IDLE));
   endtask

   // One access from the IDLE sampling cycle back to the next IDLE cycle.
   // lat = BUSY cycles before the memory acks; negative = never acks.
   task automatic access(input bit is_d, input int lat, input logic [31:0] mem_data);
      logic [31:0] exp_addr, exp_wdata, exp_rdata;
      bit          exp_w, timed_out;
      int          busy;
      exp_addr  = is_d ? bus.d_addr : bus.i_addr;
      exp_w     = is_d && bus.d_write;
      exp_wdata = bus.d_wdata;
      timed_out = (lat < 0) || (lat >= int'(TO));
      busy      = timed_out ? int'(TO) : lat + 1;
      exp_rdata = (timed_out || exp_w) ? 32'h0 : mem_data;
      tick();
      for (int k = 0; k < busy; k++) begin
         check("busy m_req", 32'(bus.m_req), 32'd1);
         check("busy m_addr", bus.m_addr, exp_addr);
         check("busy m_write", 32'(bus.m_write), 32'(exp_w));
         if (exp_w) check("busy m_wdata", bus.m_wdata, exp_wdata);
         check("busy acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
         if (k == lat) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = mem_data;
         end
         tick();
         bus.m_ack   = 1'b0;
         bus.m_rdata = $urandom;
      end
      check("resp m_req", 32'(bus.m_req), 32'd0);
      check("resp i_ack", 32'(bus.i_ack), 32'(!is_d));
      check("resp d_ack", 32'(bus.d_ack), 32'(is_d));
      check("resp rdata", is_d ? bus.d_rdata : bus.i_rdata, exp_rdata);
      check("resp err", 32'(bus.err), 32'(timed_out));
      if (is_d) bus.d_req = 1'b0;
      else      bus.i_req = 1'b0;
      model_last_d = is_d;
      bus.m_ack = timed_out;   // late memory ack after an abort is ignored
      tick();
      bus.m_ack = 1'b0;
      check("idle acks", {29'd0, bus.m_req, bus.i_ack, bus.d_ack}, 32'd0);
      check("idle state", 32'(dut.state_q), 32'(ARB_IDLE));
   endtask

   initial begin
      reset       = 1'b1;
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = '0;
      model_last_d = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check_all_zero("reset");

      // Zero-wait fetch
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h100;
      access(1'b0, 0, 32'hDEADBEEF);

      // Store with three wait cycles (ack lands on the last allowed cycle)
      bus.d_req   = 1'b1;
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h40;
      bus.d_wdata = 32'h12345678;
      access(1'b1, 3, 32'hCAFEF00D);

      // Simultaneous requests, repeated; loser keeps its request held
      for (int t = 0; t < 4; t++) begin
         bus.i_req   = 1'b1;
         bus.i_addr  = 32'h200 + 32'(t * 4);
         bus.d_req   = 1'b1;
         bus.d_write = 1'b0;
         bus.d_addr  = 32'h300 + 32'(t * 4);
         while (bus.i_req || bus.d_req)
            access(pick_d(bus.i_req, bus.d_req), 1, $urandom);
      end

      // Memory never acks: timeout, then a normal access
      bus.d_req   = 1'b1;
      bus.d_write = 1'b0;
      bus.d_addr  = 32'h80;
      access(1'b1, -1, 32'h0BADF00D);
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h104;
      access(1'b0, 0, 32'h01234567);

      // Randomized traffic, latencies spanning both sides of the timeout
      for (int n = 0; n < 40; n++) begin
         int unsigned sel;
         sel = $urandom_range(1, 3);
         bus.i_req   = sel[0];
         bus.d_req   = sel[1];
         bus.i_addr  = $urandom;
         bus.d_addr  = $urandom;
         bus.d_write = 1'($urandom_range(0, 1));
         bus.d_wdata = $urandom;
         while (bus.i_req || bus.d_req)
            access(pick_d(bus.i_req, bus.d_req), int'($urandom_range(0, 5)), $urandom);
      end

      // Reset in the middle of BUSY, memory acks after reset is released
      bus.d_req   = 1'b1;
      bus.d_write = 1'b0;
      bus.d_addr  = 32'h500;
      tick();
      tick();
      check("pre-reset m_req", 32'(bus.m_req), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async reset m_req", 32'(bus.m_req), 32'd0);
      check("async reset acks", {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      bus.d_req = 1'b0;
      model_last_d = 1'b0;
      tick();
      reset       = 1'b0;
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h55AA55AA;
      tick();
      bus.m_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_all_zero("post-reset");
         tick();
      end

      // After reset the first conflict is resolved as from a fresh start
      bus.i_req   = 1'b1;
      bus.i_addr  = 32'h600;
      bus.d_req   = 1'b1;
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h700;
      bus.d_wdata = 32'hA5A5A5A5;
      while (bus.i_req || bus.d_req)
         access(pick_d(bus.i_req, bus.d_req), 2, $urandom);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
